// File: rtl/lsu_align.sv
// lsu_align: load/store alignment unit in front of a word-only data memory.
// Accepts one B/H/W load or store request at a time. Loads are done as a
// word read followed by lane extraction and sign or zero extension. Sub-word
// stores are done as read-modify-write, because the memory only has a
// whole-word write enable. Misaligned accesses and illegal funct3 codes get
// an error response and never reach memory.
//
// Ports:
//   i_clk, i_rst_n           clock, asynchronous active-low reset
//   i_req_valid/o_req_ready  request handshake (ready only when idle)
//   i_req_we                 1 = store, 0 = load
//   i_req_funct3             000 B, 001 H, 010 W, 100 BU, 101 HU
//   i_req_addr, i_req_wdata  byte address, right-aligned store data
//   o_resp_valid             one-cycle completion pulse
//   o_resp_rdata, o_resp_err extended load data / error flag (held)
//   o_dmem_addr/_wdata/_we   word-aligned memory port
//   i_dmem_rdata             combinational read data at o_dmem_addr
module lsu_align (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [2:0]  i_req_funct3,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_resp_valid,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_err,
  output logic [31:0] o_dmem_addr,
  output logic [31:0] o_dmem_wdata,
  output logic        o_dmem_we,
  input  logic [31:0] i_dmem_rdata
);

  typedef enum logic [1:0] {StIdle, StAccess, StMergeWr} state_e;

  state_e      r_state, w_state_d;
  logic        r_we, w_we_d;
  logic [2:0]  r_funct3, w_funct3_d;
  logic [31:0] r_addr, w_addr_d;
  logic [31:0] r_wdata, w_wdata_d;
  logic [31:0] r_merge, w_merge_d;
  logic        r_resp_valid, w_resp_valid_d;
  logic [31:0] r_resp_rdata, w_resp_rdata_d;
  logic        r_resp_err, w_resp_err_d;

  logic        w_accept;
  logic        w_req_err;
  logic [7:0]  w_lane_b;
  logic [15:0] w_lane_h;
  logic [31:0] w_load_data;
  logic [31:0] w_merged;
  logic        w_is_sw;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_we         <= 1'b0;
      r_funct3     <= 3'b000;
      r_addr       <= 32'h0;
      r_wdata      <= 32'h0;
      r_merge      <= 32'h0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'h0;
      r_resp_err   <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_we         <= w_we_d;
      r_funct3     <= w_funct3_d;
      r_addr       <= w_addr_d;
      r_wdata      <= w_wdata_d;
      r_merge      <= w_merge_d;
      r_resp_valid <= w_resp_valid_d;
      r_resp_rdata <= w_resp_rdata_d;
      r_resp_err   <= w_resp_err_d;
    end
  end

  always_comb begin
    w_accept = i_req_valid && (r_state == StIdle);

    // Illegal codes, stores of BU/HU, misaligned half and word accesses.
    w_req_err = (i_req_funct3 == 3'b011) || (i_req_funct3 == 3'b110) ||
                (i_req_funct3 == 3'b111) || (i_req_we && i_req_funct3[2]) ||
                ((i_req_funct3[1:0] == 2'b01) && i_req_addr[0]) ||
                ((i_req_funct3 == 3'b010) && (i_req_addr[1:0] != 2'b00));

    w_lane_b = i_dmem_rdata[{r_addr[1:0], 3'b000} +: 8];
    w_lane_h = i_dmem_rdata[{r_addr[1], 4'b0000} +: 16];
    unique case (r_funct3)
      3'b000:  w_load_data = {{24{w_lane_b[7]}}, w_lane_b};
      3'b100:  w_load_data = {24'h0, w_lane_b};
      3'b001:  w_load_data = {{16{w_lane_h[15]}}, w_lane_h};
      3'b101:  w_load_data = {16'h0, w_lane_h};
      default: w_load_data = i_dmem_rdata;
    endcase

    w_merged = r_merge;
    if (r_funct3[1:0] == 2'b00) begin
      w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
    end else begin
      w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
    end

    // Only legal stores are latched, so funct3 010 means SW here.
    w_is_sw = r_we && (r_funct3 == 3'b010);

    w_state_d      = r_state;
    w_we_d         = r_we;
    w_funct3_d     = r_funct3;
    w_addr_d       = r_addr;
    w_wdata_d      = r_wdata;
    w_merge_d      = r_merge;
    w_resp_valid_d = 1'b0;
    w_resp_rdata_d = r_resp_rdata;
    w_resp_err_d   = r_resp_err;

    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          if (w_req_err) begin
            w_resp_valid_d = 1'b1;
            w_resp_err_d   = 1'b1;
            w_resp_rdata_d = 32'h0;
          end else begin
            w_we_d     = i_req_we;
            w_funct3_d = i_req_funct3;
            w_addr_d   = i_req_addr;
            w_wdata_d  = i_req_wdata;
            w_state_d  = StAccess;
          end
        end
      end
      StAccess: begin
        if (!r_we || w_is_sw) begin
          w_resp_valid_d = 1'b1;
          w_resp_err_d   = 1'b0;
          w_resp_rdata_d = r_we ? 32'h0 : w_load_data;
          w_state_d      = StIdle;
        end else begin
          w_merge_d = i_dmem_rdata;
          w_state_d = StMergeWr;
        end
      end
      StMergeWr: begin
        w_resp_valid_d = 1'b1;
        w_resp_err_d   = 1'b0;
        w_resp_rdata_d = 32'h0;
        w_state_d      = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Memory write enable is decoded from state so reset drops it immediately.
  assign o_req_ready  = (r_state == StIdle);
  assign o_dmem_addr  = {r_addr[31:2], 2'b00};
  assign o_dmem_we    = ((r_state == StAccess) && w_is_sw) || (r_state == StMergeWr);
  assign o_dmem_wdata = (r_state == StMergeWr) ? w_merged : r_wdata;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_rdata = r_resp_rdata;
  assign o_resp_err   = r_resp_err;

endmodule

// File: doc/lsu_align.md
# lsu_align

Load/store alignment unit sitting directly upstream of the word-only data memory in the single-cycle core. It accepts one byte/half/word load or store request at a time from the execute stage. Loads are performed as word-aligned reads with lane extraction and sign/zero extension. Sub-word stores are performed as a read-modify-write sequence, because the data memory has only a whole-word write enable. Misaligned accesses and illegal funct3 codes are rejected with an error response and never touch memory.

## Interface
- No parameters (data and address width fixed at 32).
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request (high only in IDLE)
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle pulse, request finished
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  qualifies resp_valid: misaligned or illegal funct3
- dmem_addr  out  32  word address to memory, {addr[31:2],2'b00}
- dmem_wdata  out  32  word write data to memory
- dmem_we  out  1  memory write enable
- dmem_rdata  in  32  combinational read data from memory at dmem_addr

## Operation
- Handshake: a request is accepted when req_valid && req_ready. The unit latches we, funct3, addr and wdata. Inputs are don't-care afterwards.
- States:
  - IDLE: req_ready=1, dmem_we=0.
  - ACCESS: memory read or word write.
  - MERGE_WR: sub-word write.
- Error check at accept:
  - Half access with addr[0]=1 is an error.
  - Word access with addr[1:0]≠0 is an error.
  - Funct3 011, 110 or 111 is an error.
  - Store with funct3 100 or 101 is an error.
  - On error: stay in IDLE; on the next edge resp_valid=1, resp_err=1, resp_rdata=0; no dmem_we.
- Accepted valid request: go to ACCESS. dmem_addr is driven from the latched address from ACCESS onward. It holds its last value in IDLE.
- Load in ACCESS:
  - Select lane k=addr[1:0] for a byte, h=addr[1] for a half.
  - Sign-extend for B/H; zero-extend for BU/HU; pass W through.
  - Register the result into resp_rdata; go to IDLE with resp_valid=1.
- SW in ACCESS: dmem_we=1, dmem_wdata=latched wdata; go to IDLE with resp_valid=1.
- SB/SH in ACCESS: capture dmem_rdata into the merge register. In MERGE_WR, replace the byte or half:
  - SB: bits [8k+7:8k] ← wdata[7:0].
  - SH: bits [16h+15:16h] ← wdata[15:0].
  - Drive dmem_wdata=merged word, dmem_we=1; go to IDLE with resp_valid=1.
- resp_valid is high for exactly one cycle. resp_rdata and resp_err hold until the next response.

## Timing
- Request accepted at cycle N:
  - Load and SW: ACCESS in N+1, resp_valid in N+2.
  - SB/SH: read in N+1, write in N+2, resp_valid in N+3.
  - Error: resp_valid in N+1.
- Back-to-back: a new request may be accepted in the same cycle resp_valid is high. Best-case throughput is one load/SW every 2 cycles.
- dmem_we is high only in ACCESS(SW) or MERGE_WR, for exactly one cycle per store.
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, dmem_we=0, dmem_addr=0, dmem_wdata=0.
- Reset asserted mid-operation: return to IDLE at once and drop dmem_we asynchronously. A sub-word store interrupted before MERGE_WR performs no write, and no resp_valid is issued for the aborted request.
- req_valid while busy: ignored (req_ready=0); the requester holds it.

## Test plan
- Memory word 0x100 = 0x8899AABB; LB at 0x101 → resp_rdata 0xFFFFFFAA in N+2. LBU at 0x103 → 0x00000088. LH at 0x102 → 0xFFFF8899.
- SB 0x11 to 0x102 over 0x8899AABB → one dmem_we pulse in N+2 writing 0x8811AABB; resp_valid in N+3; no write in N+1.
- SW 0xDEADBEEF to 0x200 → dmem_we only in N+1; readback LW returns 0xDEADBEEF.
- LW at 0x202, SH at 0x201, store with funct3 100 → each gives resp_err=1 in N+1 and never raises dmem_we.
- Assert rst_n low during the ACCESS cycle of an SH → no write; outputs at reset values; the next accepted LW completes normally.
- Back-to-back LW, SB, LW with req_valid held high → requests accepted only in IDLE; responses arrive in order at the stated latencies.
